// File: rtl/maxpool_unit.sv
// maxpool_unit: streaming 2x2 / stride-2 max-pool over a raster pixel stream.
// Ports: clk, rst (async, active-high), clr (sync frame abort),
//   din_vld/din (input pixel), dout/dout_vld/dout_end (pooled pixel), busy.
module maxpool_unit #(
   parameter int N       = 8,
   parameter int IN_SIZE = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         din_vld,
   input  logic [N-1:0] din,
   output logic [N-1:0] dout,
   output logic         dout_vld,
   output logic         dout_end,
   output logic         busy
);

   localparam int OUT_SIZE = IN_SIZE / 2;
   localparam int CW = (IN_SIZE > 2) ? $clog2(IN_SIZE) : 1;
   localparam int LW = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
   localparam logic [CW-1:0] LAST  = CW'(IN_SIZE - 1);
   localparam logic [CW-1:0] PLAST = CW'(2 * OUT_SIZE - 1);
   // Odd sizes carry a trailing column/row that never forms a window.
   localparam bit ODD = (IN_SIZE % 2) == 1;

   logic [CW-1:0] col_q, col_d;
   logic [CW-1:0] row_q, row_d;
   logic [N-1:0]  hold_q, hold_d;
   logic [N-1:0]  dout_q, dout_d;
   logic          vld_q, vld_d;
   logic          end_q, end_d;
   logic          busy_q, busy_d;

   // Horizontal pair maxima of the most recent even row.
   logic [N-1:0]  linebuf [OUT_SIZE];

   logic          col_last;
   logic          row_last;
   logic          col_ok;
   logic          row_ok;
   logic [N-1:0]  hmax;
   logic [N-1:0]  lb_rd;
   logic [N-1:0]  win;
   logic [LW-1:0] lb_idx;
   logic          lb_we;

   always_comb begin
      col_last = (col_q == LAST);
      row_last = (row_q == LAST);
      col_ok   = !(ODD && col_last);
      row_ok   = !(ODD && row_last);
      hmax     = (din > hold_q) ? din : hold_q;
      lb_idx   = LW'(col_q >> 1);
      lb_rd    = linebuf[lb_idx];
      win      = (lb_rd > hmax) ? lb_rd : hmax;
   end

   always_comb begin
      col_d  = col_q;
      row_d  = row_q;
      hold_d = hold_q;
      dout_d = dout_q;
      vld_d  = 1'b0;
      end_d  = 1'b0;
      busy_d = busy_q;
      lb_we  = 1'b0;
      if (clr) begin
         // Abort wins over a coincident pixel, which is dropped.
         col_d  = '0;
         row_d  = '0;
         busy_d = 1'b0;
      end else if (din_vld) begin
         if (col_last) begin
            col_d = '0;
            row_d = row_last ? '0 : row_q + CW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
         busy_d = !(col_last && row_last);
         if (col_ok) begin
            if (!col_q[0]) begin
               hold_d = din;
            end else if (row_ok) begin
               if (!row_q[0]) begin
                  lb_we = 1'b1;
               end else begin
                  vld_d  = 1'b1;
                  dout_d = win;
                  end_d  = (col_q == PLAST) && (row_q == PLAST);
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q  <= '0;
         row_q  <= '0;
         hold_q <= '0;
         dout_q <= '0;
         vld_q  <= 1'b0;
         end_q  <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         col_q  <= col_d;
         row_q  <= row_d;
         hold_q <= hold_d;
         dout_q <= dout_d;
         vld_q  <= vld_d;
         end_q  <= end_d;
         busy_q <= busy_d;
      end
   end

   // Always written on an even row before the odd row reads it.
   always_ff @(posedge clk) begin
      if (lb_we) begin
         linebuf[lb_idx] <= hmax;
      end
   end

   assign dout     = dout_q;
   assign dout_vld = vld_q;
   assign dout_end = end_q;
   assign busy     = busy_q;

endmodule
